pma_serializer_10b: RTL and testbench
=====================================

# pma_serializer_10b

Transmit-side PMA serializer directly downstream of the PCS running-disparity selector. Generates the divide-by-10 word clock `Bit_Rate_10` from the bit clock, which paces the PCS stage. It captures each 10-bit code group `Data_10` and shifts it out serially, bit 0 first. Also supplies electrical-idle output and a built-in PRBS7 test pattern for link bring-up.

## Interface
Parameters:
- `PRBS_SEED`, 7'h7F: LFSR value loaded on reset; must be non-zero.
- `IDLE_LEVEL`, 1'b0: `TX_Out` level driven during idle words.

Ports:
- `Bit_Rate_CLK`, in, 1: serial bit clock; all logic on its rising edge.
- `Rst`, in, 1: reset, asynchronous, active-low.
- `Data_10`, in, 10: code group from the PCS; bit 0 ("a") is transmitted first.
- `enable_PMA`, in, 1: PCS word valid; low means send idle.
- `prbs_en`, in, 1: select PRBS7 instead of `Data_10`.
- `Bit_Rate_10`, out, 1: word clock, bit clock / 10, registered, 50% duty.
- `TX_Out`, out, 1: serial data, registered.
- `tx_idle`, out, 1: high while the word on `TX_Out` is an idle word.
- `word_start`, out, 1: one-bit-clock pulse coincident with the first bit of each serialized word.

## Operation
- Phase counter `cnt` runs 0..9 and wraps 9→0. `Bit_Rate_10` is registered from the next count: it is 1 when next `cnt` is 0..4 and 0 when it is 5..9. Its rising edge coincides with the edge at which `cnt` becomes 0.
- Capture happens on the edge where `cnt`==4, mid-word, after the PCS output has settled following the `Bit_Rate_10` rise.
  - `hold` <= `Data_10`.
  - `hold_idle` <= ~`enable_PMA`.
  - `hold_prbs` <= `prbs_en`.
- Load happens on the edge where `cnt`==9.
  - `shreg` <= `hold`.
  - `cur_idle` <= `hold_idle`.
  - `cur_prbs` <= `hold_prbs`.
- For the next 10 bit clocks, the source of `TX_Out` is:
  - `cur_prbs`=1: the LFSR output bit. Highest priority, sent even if `cur_idle`=1; `tx_idle`=0.
  - else `cur_idle`=1: `IDLE_LEVEL`; `tx_idle`=1.
  - else: `shreg[0]`, with `shreg` shifting right by one each bit clock.
- PRBS7 is x^7+x^6+1, Fibonacci form, output bit = `lfsr[6]`. The LFSR advances only on bit clocks whose word has `cur_prbs`=1 and holds otherwise, so the sequence resumes across mode changes.
- Modes change only at word boundaries. A `prbs_en`/`enable_PMA` toggle mid-word never corrupts a word in flight.
- `word_start` = 1 on the bit clock where the first bit of a word is driven (`cnt`==0 after the load).

## Timing
- Reset values (asynchronous on `Rst`=0):
  - `cnt`=0, `Bit_Rate_10`=0, `TX_Out`=`IDLE_LEVEL`, `tx_idle`=1, `word_start`=0.
  - `shreg`=0, `hold`=0, `hold_idle`=1, `cur_idle`=1, `hold_prbs`=0, `cur_prbs`=0, `lfsr`=`PRBS_SEED`.
- First edge after `Rst` release: `cnt`=1, `Bit_Rate_10`=1.
  - First capture is at `cnt`==4, first load at `cnt`==9.
  - The first word (idle, from reset `hold` values) appears at `cnt`==0 of the second word period.
- Latency: a word presented after the `Bit_Rate_10` rise of period N drives its bit 0 on `TX_Out` at the first bit clock of period N+1, i.e. 10 bit clocks after that rise.
- `TX_Out` and `tx_idle` change only on bit-clock edges. `tx_idle` is constant for all 10 bits of a word.
- Reset mid-word: outputs go to reset values immediately. Any partially sent word is lost and nothing resumes from it.
- `Data_10` need only be stable across the `cnt`==4 edge (5-bit-clock setup window from the `Bit_Rate_10` rise).

## Test plan
- Reset, then 25 bit clocks with `enable_PMA`=0.
  - During `Rst`=0: `Bit_Rate_10`=0, `TX_Out`=0, `tx_idle`=1.
  - After release: `Bit_Rate_10` is high for 5 and low for 5 bit clocks per period, and `tx_idle` stays 1.
- `enable_PMA`=1, `Data_10`=10'b0101111100 (K28.5 RD−, abcdei fghj 001111 1010), held 3 words.
  - `TX_Out` repeats 0,0,1,1,1,1,1,0,1,0.
  - `word_start` pulses on each leading 0.
  - `tx_idle`=0.
- Alternate 10'h17C / 10'h283 every `Bit_Rate_10` rise.
  - Serial stream alternates K28.5 RD−/RD+ with exactly 10-bit-clock latency.
  - No bit slips over 100 words.
- Toggle `enable_PMA` low at `cnt`==6.
  - The current word completes unaltered.
  - The next word captured with `enable_PMA`=0 is idle: `TX_Out`=0 and `tx_idle`=1 for exactly 10 bits.
- `prbs_en`=1 from a seed of 7'h7F.
  - 127 consecutive bits match the reference PRBS7 sequence and then repeat with period 127.
  - Dropping `prbs_en` for 2 words, then restoring it, continues the sequence where it stopped.
- Assert `Rst`=0 at `cnt`==3 during data.
  - All outputs reach reset values asynchronously.
  - After release, restart timing is identical to the first scenario.

Source files
------------

// File: rtl/pma_serializer_10b.sv
// pma_serializer_10b
// Transmit PMA serializer: divides the bit clock by 10 to make the PCS word
// clock, captures one 10-bit code group per word period and shifts it out
// LSB ("a") first. Per word it can send PCS data, electrical idle, or PRBS7.
//
// Word handshake: enable_PMA is the valid for Data_10 and has no ready.
// The PCS is paced by Bit_Rate_10 and must present a word at each rising
// edge of that clock. The word is taken at the mid-period capture edge
// (cnt==4). A word with enable_PMA low is replaced by an idle word.
module pma_serializer_10b #(
   parameter logic [6:0] PRBS_SEED  = 7'h7F,
   parameter logic       IDLE_LEVEL = 1'b0
) (
   input  logic       Bit_Rate_CLK,
   input  logic       Rst,
   input  logic [9:0] Data_10,
   input  logic       enable_PMA,
   input  logic       prbs_en,
   output logic       Bit_Rate_10,
   output logic       TX_Out,
   output logic       tx_idle,
   output logic       word_start
);

   logic [3:0] cnt;
   logic [3:0] cnt_nxt;
   logic [9:0] hold;
   logic [9:0] shreg;
   logic [9:0] shreg_nxt;
   logic       hold_idle;
   logic       hold_prbs;
   logic       cur_idle;
   logic       cur_prbs;
   logic [6:0] lfsr;
   logic [6:0] lfsr_nxt;
   logic       load;
   logic       capture;
   logic       sel_prbs;
   logic       sel_idle;
   logic       data_bit;
   logic       tx_nxt;
   logic       tx_idle_nxt;

   // Next-state for the phase counter, the shifter and the bit source.
   // On the load edge the registered output takes bit 0 straight from the
   // hold stage, so shreg[1] is always the bit driven on the following edge.
   always_comb begin
      cnt_nxt     = (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
      load        = (cnt == 4'd9);
      capture     = (cnt == 4'd4);
      sel_prbs    = load ? hold_prbs : cur_prbs;
      sel_idle    = load ? hold_idle : cur_idle;
      data_bit    = load ? hold[0]   : shreg[1];
      shreg_nxt   = load ? hold      : {1'b0, shreg[9:1]};
      lfsr_nxt    = lfsr;
      tx_nxt      = data_bit;
      tx_idle_nxt = 1'b0;
      if (sel_prbs) begin
         // x^7 + x^6 + 1, Fibonacci form, output taken from lfsr[6]
         tx_nxt   = lfsr[6];
         lfsr_nxt = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      end else if (sel_idle) begin
         tx_nxt      = IDLE_LEVEL;
         tx_idle_nxt = 1'b1;
      end
   end

   // Phase counter and the registered 50% duty word clock.
   always_ff @(posedge Bit_Rate_CLK or negedge Rst) begin
      if (!Rst) begin
         cnt         <= 4'd0;
         Bit_Rate_10 <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         Bit_Rate_10 <= (cnt_nxt < 4'd5);
      end
   end

   // Mid-period capture into hold, word-boundary transfer into the shifter.
   always_ff @(posedge Bit_Rate_CLK or negedge Rst) begin
      if (!Rst) begin
         hold      <= 10'd0;
         hold_idle <= 1'b1;
         hold_prbs <= 1'b0;
         cur_idle  <= 1'b1;
         cur_prbs  <= 1'b0;
      end else begin
         if (capture) begin
            hold      <= Data_10;
            hold_idle <= ~enable_PMA;
            hold_prbs <= prbs_en;
         end
         if (load) begin
            cur_idle <= hold_idle;
            cur_prbs <= hold_prbs;
         end
      end
   end

   // Serial path: shifter, PRBS generator and the registered line outputs.
   always_ff @(posedge Bit_Rate_CLK or negedge Rst) begin
      if (!Rst) begin
         shreg      <= 10'd0;
         lfsr       <= PRBS_SEED;
         TX_Out     <= IDLE_LEVEL;
         tx_idle    <= 1'b1;
         word_start <= 1'b0;
      end else begin
         shreg      <= shreg_nxt;
         lfsr       <= lfsr_nxt;
         TX_Out     <= tx_nxt;
         tx_idle    <= load ? tx_idle_nxt : tx_idle;
         word_start <= load;
      end
   end

endmodule

// File: tb/tb_pma_serializer_10b.sv
// tb_pma_serializer_10b
// Checks pma_serializer_10b against a word-level reference: each captured
// word is expanded into a queue of ten expected {word_start, idle, bit}
// entries, with PRBS bits taken from a precomputed 127-entry sequence.
module tb_pma_serializer_10b;

  localparam logic [6:0] SEED     = 7'h7F;
  localparam logic       IDLE_LVL = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] data_10 = 10'd0;
  logic       enable_pma = 1'b0;
  logic       prbs_en = 1'b0;
  logic       bit_rate_10;
  logic       tx_out;
  logic       tx_idle;
  logic       word_start;

  int checks = 0;
  int errors = 0;

  pma_serializer_10b #(.PRBS_SEED(SEED), .IDLE_LEVEL(IDLE_LVL)) dut (
    .Bit_Rate_CLK(clk),
    .Rst(rst),
    .Data_10(data_10),
    .enable_PMA(enable_pma),
    .prbs_en(prbs_en),
    .Bit_Rate_10(bit_rate_10),
    .TX_Out(tx_out),
    .tx_idle(tx_idle),
    .word_start(word_start)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference PRBS7 output sequence: s[k+7] = s[k] ^ s[k+1], seed all ones
  logic prbs_ref[127];

  // scoreboard: per-bit expectations {word_start, idle, bit}
  logic [2:0] exp_q[$];
  int         m_cnt = 0;
  int         m_ptr = 0;
  logic [9:0] m_word = 10'd0;
  logic       m_idle = 1'b1;
  logic       m_prbs = 1'b0;
  logic [2:0] m_cur = {1'b0, 1'b1, IDLE_LVL};
  logic       m_br = 1'b0;
  logic       m_b;
  logic       m_id;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_ptr = 0; m_word = 10'd0; m_idle = 1'b1; m_prbs = 1'b0;
      exp_q.delete();
      m_cur = {1'b0, 1'b1, IDLE_LVL};
      m_br  = 1'b0;
    end else begin
      if (m_cnt == 4) begin
        m_word = data_10; m_idle = ~enable_pma; m_prbs = prbs_en;
      end
      if (m_cnt == 9) begin
        for (int i = 0; i < 10; i++) begin
          if (m_prbs) begin
            m_b = prbs_ref[m_ptr]; m_ptr = (m_ptr + 1) % 127; m_id = 1'b0;
          end else if (m_idle) begin
            m_b = IDLE_LVL; m_id = 1'b1;
          end else begin
            m_b = m_word[i]; m_id = 1'b0;
          end
          exp_q.push_back({(i == 0), m_id, m_b});
        end
      end
      m_cur = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b0, 1'b1, IDLE_LVL};
      m_cnt = (m_cnt + 1) % 10;
      m_br  = (m_cnt < 5);
    end
  end

  // per-bit comparison, sampled well after the active edge
  always @(posedge clk) begin
    #3;
    if (!rst) begin
      check("rst_br",   bit_rate_10, 0);
      check("rst_tx",   tx_out, IDLE_LVL);
      check("rst_idle", tx_idle, 1);
      check("rst_ws",   word_start, 0);
    end else begin
      check("br",   bit_rate_10, m_br);
      check("tx",   tx_out, m_cur[0]);
      check("idle", tx_idle, m_cur[1]);
      check("ws",   word_start, m_cur[2]);
    end
  end

  // driver tasks
  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    @(negedge clk);
    while (m_cnt != v && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (m_cnt != v) check("wait_cnt_timeout", m_cnt, v);
  endtask

  task automatic grab_word(output logic [9:0] w);
    int n;
    w = 10'd0;
    n = 0;
    @(posedge clk); #3;
    while (!word_start && n < 30) begin
      @(posedge clk); #3;
      n++;
    end
    check("ws_seen", word_start, 1);
    for (int i = 0; i < 10; i++) begin
      w[i] = tx_out;
      @(posedge clk); #3;
    end
  endtask

  initial begin
    logic [9:0] got;
    for (int k = 0; k < 7; k++) prbs_ref[k] = 1'b1;
    for (int k = 7; k < 127; k++) prbs_ref[k] = prbs_ref[k-7] ^ prbs_ref[k-6];

    // reset, then idle period
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);

    // K28.5 RD- held for several words
    enable_pma = 1'b1;
    data_10 = 10'b0101111100;
    repeat (25) @(negedge clk);
    grab_word(got);
    check("k28_word", got, 10'h17C);
    @(negedge clk);

    // alternate RD-/RD+ every word clock rise
    for (int w = 0; w < 100; w++) begin
      wait_cnt(0);
      data_10 = w[0] ? 10'h283 : 10'h17C;
    end
    repeat (10) @(negedge clk);

    // drop valid mid-word
    wait_cnt(6);
    enable_pma = 1'b0;
    repeat (30) @(negedge clk);

    // PRBS7 across more than two full periods
    prbs_en = 1'b1;
    repeat (300) @(negedge clk);
    wait_cnt(6);
    prbs_en = 1'b0;
    enable_pma = 1'b1;
    data_10 = 10'($urandom);
    repeat (20) @(negedge clk);
    prbs_en = 1'b1;
    repeat (200) @(negedge clk);

    // random data with random mode changes at any phase
    prbs_en = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      data_10 = 10'($urandom);
      if ($urandom_range(0, 19) == 0) enable_pma = ~enable_pma;
      if ($urandom_range(0, 29) == 0) prbs_en = ~prbs_en;
    end

    // reset in the middle of a data word
    enable_pma = 1'b1;
    prbs_en = 1'b0;
    data_10 = 10'($urandom);
    repeat (30) @(negedge clk);
    wait_cnt(3);
    rst = 1'b0;
    #1;
    check("async_br",   bit_rate_10, 0);
    check("async_tx",   tx_out, IDLE_LVL);
    check("async_idle", tx_idle, 1);
    check("async_ws",   word_start, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
